// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one stage boundary: upstream valid/ready/data in, downstream valid/ready/data out.
// The slave modport is the register stage; the master modport is whatever surrounds it.
interface pipe_stage_skid_if #(
   parameter int unsigned DATA_W = 32
);
   logic              in_valid_i;
   logic              in_ready_o;
   logic [DATA_W-1:0] in_data_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [DATA_W-1:0] out_data_o;

   modport master (
      output in_valid_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o
   );

   modport slave (
      input  in_valid_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage register with 2-entry skid buffer, registered ready, flush with field kill,
// and a saturating back-pressure counter.
module pipe_stage_skid #(
   parameter int unsigned       DATA_W    = 32,
   parameter logic [DATA_W-1:0] KILL_MASK = '0,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                stall_clr_i,
   pipe_stage_skid_if.slave    bus,
   output logic [1:0]          occupancy_o,
   output logic [CNT_W-1:0]    stall_cnt_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e            r_state;
   state_e            w_state_nxt;
   logic              r_in_ready;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_in_fire;
   logic w_out_fire;
   logic w_out_valid;
   logic w_main_from_in;
   logic w_main_from_skid;
   logic w_skid_from_in;
   logic w_stall;

   assign w_in_fire  = bus.in_valid_i & r_in_ready;
   assign w_out_fire = w_out_valid & bus.out_ready_i;

   // Ready is registered from the next state, so out_ready_i never reaches in_ready_o combinationally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != FULL);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: if (w_in_fire) w_state_nxt = BUSY;
         BUSY: begin
            if (w_in_fire && !w_out_fire)      w_state_nxt = FULL;
            else if (!w_in_fire && w_out_fire) w_state_nxt = EMPTY;
         end
         FULL:    if (w_out_fire) w_state_nxt = BUSY;
         default: w_state_nxt = EMPTY;
      endcase
      if (flush_i) w_state_nxt = EMPTY;
   end

   always_comb begin
      w_out_valid      = (r_state != EMPTY);
      occupancy_o      = {r_state == FULL, r_state == BUSY};
      w_main_from_in   = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
      case (r_state)
         EMPTY: w_main_from_in = w_in_fire;
         BUSY: begin
            w_main_from_in = w_in_fire & w_out_fire;
            w_skid_from_in = w_in_fire & ~w_out_fire;
         end
         FULL:    w_main_from_skid = w_out_fire;
         default: ;
      endcase
      w_stall = w_out_valid & ~bus.out_ready_i & ~flush_i;
   end

   // On flush only the killed fields are cleared; the rest of each entry holds.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_main <= RESET_VAL;
         r_skid <= RESET_VAL;
      end else if (flush_i) begin
         r_main <= r_main & ~KILL_MASK;
         r_skid <= r_skid & ~KILL_MASK;
      end else begin
         if (w_main_from_in)        r_main <= bus.in_data_i;
         else if (w_main_from_skid) r_main <= r_skid;
         if (w_skid_from_in)        r_skid <= bus.in_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stall_cnt <= '0;
      end else if (stall_clr_i) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.in_ready_o  = r_in_ready;
   assign bus.out_valid_o = w_out_valid;
   assign bus.out_data_o  = r_main;
   assign stall_cnt_o     = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid against a queue-based reference model.
module tb_pipe_stage_skid;

   localparam int unsigned DW  = 32;
   localparam int unsigned CW  = 3;
   localparam int unsigned SAT = 7;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          flush_i = 1'b0;
   logic          stall_clr_i = 1'b0;
   logic [1:0]    occupancy_o;
   logic [CW-1:0] stall_cnt_o;

   pipe_stage_skid_if #(.DATA_W(DW)) bus ();

   pipe_stage_skid #(
      .DATA_W   (DW),
      .KILL_MASK(32'h0000_001F),
      .RESET_VAL(32'hDEAD_BEEF),
      .CNT_W    (CW)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .stall_clr_i(stall_clr_i),
      .bus        (bus),
      .occupancy_o(occupancy_o),
      .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   logic [DW-1:0] q[$];
   bit            m_ready = 1'b1;
   int unsigned   m_cnt   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("out_valid", 64'(bus.out_valid_o), 64'(q.size() != 0));
      chk("in_ready", 64'(bus.in_ready_o), 64'(m_ready));
      chk("occupancy", 64'(occupancy_o), 64'(q.size()));
      chk("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
      if (q.size() != 0) chk("out_data", 64'(bus.out_data_o), 64'(q[0]));
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check at the next negedge.
   task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r, input bit f, input bit c);
      bit inf;
      bit outf;
      bus.in_valid_i  = v;
      bus.in_data_i   = d;
      bus.out_ready_i = r;
      flush_i         = f;
      stall_clr_i     = c;
      inf  = v && m_ready;
      outf = (q.size() != 0) && r;
      if (c) m_cnt = 0;
      else if ((q.size() != 0) && !r && !f && (m_cnt < SAT)) m_cnt++;
      if (f) begin
         q.delete();
      end else begin
         if (outf) void'(q.pop_front());
         if (inf) q.push_back(d);
      end
      m_ready = (q.size() < 2);
      @(posedge clk_i);
      @(negedge clk_i);
      check_all();
   endtask

   task automatic model_reset();
      q.delete();
      m_ready = 1'b1;
      m_cnt   = 0;
   endtask

   initial begin
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = '0;
      bus.out_ready_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
      chk("rst_occupancy", 64'(occupancy_o), 64'd0);
      chk("rst_out_data", 64'(bus.out_data_o), 64'hDEAD_BEEF);
      chk("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
      rst_ni = 1'b1;
      check_all();

      // Streaming at full throughput.
      cycle(1, 32'h1, 1, 0, 0);
      cycle(1, 32'h2, 1, 0, 0);
      cycle(1, 32'h3, 1, 0, 0);
      cycle(0, 32'h0, 1, 0, 0);

      // Skid fill, then drain while 0xC waits upstream.
      cycle(1, 32'hA, 0, 0, 0);
      cycle(1, 32'hB, 0, 0, 0);
      chk("skid_full_occ", 64'(occupancy_o), 64'd2);
      cycle(1, 32'hC, 1, 0, 0);
      chk("skid_head_b", 64'(bus.out_data_o), 64'hB);
      cycle(1, 32'hC, 1, 0, 0);
      cycle(0, 32'h0, 1, 0, 0);

      // Flush in FULL with pending upstream offer.
      cycle(1, 32'h0000_00FF, 0, 0, 0);
      cycle(1, 32'h0000_01FF, 0, 0, 0);
      cycle(1, 32'h5, 0, 1, 0);
      chk("flush_mask", 64'(bus.out_data_o), 64'h0000_00E0);
      cycle(0, 32'h0, 1, 0, 0);
      cycle(0, 32'h0, 1, 0, 0);

      // Flush coinciding with delivery in BUSY.
      cycle(1, 32'h77, 0, 0, 0);
      chk("flush_out_head", 64'(bus.out_data_o), 64'h77);
      cycle(0, 32'h0, 1, 1, 0);
      cycle(0, 32'h0, 1, 0, 0);

      // Stall counter saturation and clear.
      cycle(1, 32'h9, 0, 0, 1);
      repeat (10) cycle(0, 32'h0, 0, 0, 0);
      chk("stall_sat", 64'(stall_cnt_o), 64'(SAT));
      cycle(0, 32'h0, 0, 0, 1);
      chk("stall_clr", 64'(stall_cnt_o), 64'd0);
      cycle(0, 32'h0, 0, 0, 0);
      chk("stall_resume", 64'(stall_cnt_o), 64'd1);
      cycle(0, 32'h0, 1, 0, 1);

      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 99) < 60,
               $urandom,
               $urandom_range(0, 99) < 55,
               $urandom_range(0, 99) < 4,
               $urandom_range(0, 99) < 3);
      end

      // Asynchronous reset while FULL, observed before any clock edge.
      cycle(0, 32'h0, 1, 1, 1);
      cycle(1, 32'h1234, 0, 0, 0);
      cycle(1, 32'h5678, 0, 0, 0);
      chk("pre_arst_occ", 64'(occupancy_o), 64'd2);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_out_valid", 64'(bus.out_valid_o), 64'd0);
      chk("arst_in_ready", 64'(bus.in_ready_o), 64'd1);
      chk("arst_occupancy", 64'(occupancy_o), 64'd0);
      chk("arst_out_data", 64'(bus.out_data_o), 64'hDEAD_BEEF);
      chk("arst_stall_cnt", 64'(stall_cnt_o), 64'd0);
      bus.in_valid_i = 1'b0;
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      cycle(1, 32'h4242, 1, 0, 0);
      cycle(0, 32'h0, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
